conv_frame_ctrl: RTL and testbench
==================================

CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 Parameter IMG_W, default 8: image width in pixels, >=3.
REQ-002 Parameter IMG_H, default 8: image height in pixels, >=3.
REQ-003 Parameter PIPE_LAT, default 4: cycles from pixel acceptance (stage1_en high) to the matching conv_out of the pipelined convolution, >=1.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  begin one frame; sampled only in IDLE.
REQ-007 abort  in  1  terminate the frame immediately; return to IDLE.
REQ-008 pix_valid  in  1  pixel source presents a pixel this cycle.
REQ-009 pix_ready  out  1  controller accepts a pixel this cycle; high only in FEED.
REQ-010 stage1_en  out  1  combinational pix_valid & pix_ready; drives the convolution stage-1 enable.
REQ-011 rd_addr  out  clog2(IMG_W*IMG_H)  raster index of the next pixel to request.
REQ-012 out_we  out  1  conv_out is a valid result this cycle.
REQ-013 out_addr  out  clog2((IMG_W-2)*(IMG_H-2))  raster index of the current result.
REQ-014 busy  out  1  high in FEED, DRAIN and DONE.
REQ-015 done  out  1  one-cycle pulse at end of frame.
REQ-016 frame_err  out  1  sticky; result count at DONE differed from (IMG_W-2)*(IMG_H-2).

Function
REQ-017 The FSM SHALL have states IDLE, FEED, DRAIN and DONE, encoded as registers.
REQ-018 IDLE: on start=1, go to FEED and clear row, col, rd_addr, out_addr, the drain counter and the valid delay line; frame_err is left unchanged.
REQ-019 FEED: each cycle with stage1_en=1 SHALL advance col; col wraps from IMG_W-1 to 0 and increments row; rd_addr increments by 1.
REQ-020 FEED: a cycle with pix_valid=0 is a bubble; counters SHALL hold, and a 0 is injected into the delay line.
REQ-021 On acceptance of pixel (row=IMG_H-1, col=IMG_W-1) the FSM SHALL go to DRAIN on the next edge; rd_addr then holds IMG_W*IMG_H.
REQ-022 Window flag = stage1_en & (row>=2) & (col>=2), evaluated on the pre-increment row/col of the accepted pixel.
REQ-023 A PIPE_LAT-deep shift register SHALL shift every clock in FEED and DRAIN, including bubble cycles, injecting the window flag.
REQ-024 out_we SHALL equal the last delay-line tap, so a flag injected in cycle t appears as out_we in cycle t+PIPE_LAT.
REQ-025 out_addr SHALL increment by 1 after every out_we cycle, starting from 0.
REQ-026 DRAIN SHALL last exactly PIPE_LAT cycles, then go to DONE; pix_ready=0 during DRAIN.
REQ-027 DONE SHALL last one cycle with done=1; if out_addr != (IMG_W-2)*(IMG_H-2), frame_err is set; the next state is IDLE.
REQ-028 start asserted outside IDLE SHALL be ignored.
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE on the next edge and clear the delay line; done is not pulsed; abort wins over start.
REQ-030 In IDLE, start=1 and abort=1 together SHALL leave the FSM in IDLE.
REQ-031 frame_err SHALL clear only on reset.

Reset
REQ-032 While reset=1, state SHALL be IDLE and the following SHALL be 0: row, col, rd_addr, out_addr, drain counter, delay line, out_we, done, busy, pix_ready, stage1_en, frame_err.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no done pulse; operation resumes on the first start after release.

Verification (IMG_W=IMG_H=8, PIPE_LAT=4; cycle 0 = first FEED cycle)
REQ-034 start pulse, pix_valid held high -> 64 acceptances in cycles 0..63; first out_we in cycle 22 (pixel 18 + 4); 36 out_we pulses, out_addr 0..35; DRAIN in cycles 64..67; done=1 in cycle 68; frame_err=0.
REQ-035 pix_valid low in cycles 10..12 -> every later event is shifted by 3 cycles: first out_we in cycle 25, done in cycle 71, still 36 results.
REQ-036 abort in cycle 30 -> IDLE in cycle 31; out_we=0 from cycle 31; no done pulse; a following start runs a clean 36-result frame.
REQ-037 reset asserted asynchronously in cycle 40 -> all outputs 0 immediately; a frame after release completes normally.
REQ-038 start pulsed again in cycles 5 and 66 -> ignored; exactly one done pulse, in cycle 68.

Source files
------------

// File: rtl/conv_frame_ctrl.sv
// Frame controller for a pipelined 3x3 convolution.
// Walks the image in raster order, tracks which accepted pixels complete a
// full 3x3 window, delays that flag by the convolution latency to produce
// the result write strobe, and checks the result count at end of frame.
module conv_frame_ctrl #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int PIPE_LAT = 4,
  // Address widths carry one extra count so the end-of-frame values
  // (IMG_W*IMG_H for rd_addr, the full result count for out_addr) are
  // representable without wrapping.
  localparam int NPIX = IMG_W * IMG_H,
  localparam int NRES = (IMG_W - 2) * (IMG_H - 2),
  localparam int RD_W = $clog2(NPIX + 1),
  localparam int OA_W = $clog2(NRES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic            stage1_en,
  output logic [RD_W-1:0] rd_addr,
  output logic            out_we,
  output logic [OA_W-1:0] out_addr,
  output logic            busy,
  output logic            done,
  output logic            frame_err
);

  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam int DC_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [CW-1:0]   COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(PIPE_LAT - 1);
  localparam logic [OA_W-1:0] RES_TOTAL  = OA_W'(NRES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic [OA_W-1:0]     oa_q, oa_d;
  logic [DC_W-1:0]     dcnt_q, dcnt_d;
  logic [PIPE_LAT-1:0] dly_q, dly_d;
  logic                err_q, err_d;
  logic                win;

  // Shift one window flag into the latency-matching delay line.
  function automatic logic [PIPE_LAT-1:0] shift_in(input logic [PIPE_LAT-1:0] line,
                                                    input logic             bit_in);
    logic [PIPE_LAT-1:0] r;
    r[0] = bit_in;
    for (int i = 1; i < PIPE_LAT; i++) r[i] = line[i-1];
    return r;
  endfunction

  assign rd_addr   = rd_q;
  assign out_addr  = oa_q;
  assign out_we    = dly_q[PIPE_LAT-1];
  assign frame_err = err_q;

  // State and counter registers; everything returns to idle/zero on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      rd_q    <= '0;
      oa_q    <= '0;
      dcnt_q  <= '0;
      dly_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      rd_q    <= rd_d;
      oa_q    <= oa_d;
      dcnt_q  <= dcnt_d;
      dly_q   <= dly_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic, raster counters, delay line and decoded outputs.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    rd_d      = rd_q;
    oa_d      = oa_q + OA_W'(out_we);
    dcnt_d    = dcnt_q;
    dly_d     = dly_q;
    err_d     = err_q;
    pix_ready = (state_q == S_FEED);
    stage1_en = pix_valid & pix_ready;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    // A pixel at row>=2, col>=2 is the bottom-right corner of a full window.
    win       = stage1_en && (row_q >= RW'(2)) && (col_q >= CW'(2));

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_FEED;
          row_d   = '0;
          col_d   = '0;
          rd_d    = '0;
          oa_d    = '0;
          dcnt_d  = '0;
          dly_d   = '0;
        end
      end
      S_FEED: begin
        // The line shifts on bubbles too, so latency stays fixed in cycles.
        dly_d = shift_in(dly_q, win);
        if (stage1_en) begin
          rd_d = rd_q + RD_W'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        dly_d  = shift_in(dly_q, 1'b0);
        dcnt_d = dcnt_q + DC_W'(1);
        if (dcnt_q == DRAIN_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (oa_q != RES_TOTAL) err_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every other transition and discards in-flight flags.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      dly_d   = '0;
    end
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Testbench for conv_frame_ctrl: table of whole-frame scenarios driven
// against a raster scoreboard, plus hand-written reset and start/abort cases.
module tb_conv_frame_ctrl;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int PL   = 4;
  localparam int RD_W = $clog2(W * H + 1);
  localparam int OA_W = $clog2((W - 2) * (H - 2) + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            abort;
  logic            pix_valid;
  logic            pix_ready;
  logic            stage1_en;
  logic [RD_W-1:0] rd_addr;
  logic            out_we;
  logic [OA_W-1:0] out_addr;
  logic            busy;
  logic            done;
  logic            frame_err;

  conv_frame_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(PL)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .stage1_en (stage1_en),
    .rd_addr   (rd_addr),
    .out_we    (out_we),
    .out_addr  (out_addr),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int cyc;
  } exp_t;

  typedef struct {
    int bub_s;
    int bub_n;
    int abort_c;
    int st1;
    int st2;
    int exp_first;
    int exp_done;
    int exp_ndone;
    int exp_nres;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Runs one frame from a start pulse for a fixed 80-cycle window.
  // Cycle 0 is the first FEED cycle. Every accepted pixel that closes a
  // window pushes its result address and the cycle it must appear in.
  task automatic run_frame(input vec_t v);
    int   r, c, pix, na, nres, first, donec, ndone;
    exp_t e;
    q.delete();
    r = 0; c = 0; pix = 0; na = 0; nres = 0; first = -1; donec = -1; ndone = 0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; pix_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      pix_valid = !((cyc >= v.bub_s) && (cyc < v.bub_s + v.bub_n));
      abort     = (cyc == v.abort_c);
      start     = (cyc == v.st1) || (cyc == v.st2);
      @(negedge clk);
      if (stage1_en) begin
        check("rd_addr", int'(rd_addr), pix);
        if (r >= 2 && c >= 2) begin
          q.push_back('{addr: na, cyc: cyc + PL});
          na++;
        end
        pix++;
        if (c == W - 1) begin
          c = 0;
          r++;
        end else begin
          c++;
        end
      end
      if (out_we) begin
        nres++;
        if (first < 0) first = cyc;
        if (q.size() == 0) begin
          check("out_we_spurious", cyc, -1);
        end else begin
          e = q.pop_front();
          check("out_we_cycle", cyc, e.cyc);
          check("out_addr", int'(out_addr), e.addr);
        end
      end
      if (done) begin
        ndone++;
        donec = cyc;
        check("rd_addr_end", int'(rd_addr), W * H);
        check("out_addr_end", int'(out_addr), (W - 2) * (H - 2));
      end
      if (cyc == v.abort_c) begin
        while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
      end
      if (v.abort_c >= 0 && cyc == v.abort_c + 1) begin
        check("abort_busy", int'(busy), 0);
        check("abort_out_we", int'(out_we), 0);
      end
      @(posedge clk); #1;
    end
    abort = 1'b0; start = 1'b0; pix_valid = 1'b0;
    check("first_we_cycle", first, v.exp_first);
    check("done_cycle", donec, v.exp_done);
    check("done_count", ndone, v.exp_ndone);
    check("result_count", nres, v.exp_nres);
    check("pending_results", q.size(), 0);
    check("frame_err", int'(frame_err), 0);
    check("busy_after", int'(busy), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_pix_ready"}, int'(pix_ready), 0);
    check({tag, "_stage1_en"}, int'(stage1_en), 0);
    check({tag, "_out_we"}, int'(out_we), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_rd_addr"}, int'(rd_addr), 0);
    check({tag, "_out_addr"}, int'(out_addr), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
  endtask

  vec_t vecs[5];
  int   ndone_rst;

  initial begin
    //          bub_s bub_n abort st1 st2 first done ndone nres
    vecs[0] = '{-1, 0, -1, -1, -1, 22, 68, 1, 36};  // plain frame
    vecs[1] = '{10, 3, -1, -1, -1, 25, 71, 1, 36};  // 3-cycle bubble
    vecs[2] = '{-1, 0, 30, -1, -1, 22, -1, 0, 7};   // abort in cycle 30
    vecs[3] = '{-1, 0, -1, -1, -1, 22, 68, 1, 36};  // clean frame after abort
    vecs[4] = '{-1, 0, -1, 5, 66, 22, 68, 1, 36};   // stray starts ignored

    reset = 1'b1; start = 1'b0; abort = 1'b0; pix_valid = 1'b1;
    #12;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    pix_valid = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // start and abort together in IDLE: must stay idle.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", int'(busy), 0);
    @(negedge clk);
    check("start_abort_idle2", int'(busy), 0);

    // Asynchronous reset in cycle 40 of a running frame.
    ndone_rst = 0;
    @(posedge clk); #1;
    start = 1'b1; pix_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) ndone_rst++;
      @(posedge clk); #1;
    end
    check("pre_reset_busy", int'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    check("midreset_done_count", ndone_rst, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    pix_valid = 1'b0;
    @(negedge clk);
    check("post_reset_idle", int'(busy), 0);
    run_frame(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
